// File: rtl/spi_slave_rx.sv
// SPI receive side: oversamples sclk/cs/mosi on clk, deserialises LSB-first DW-bit words
// and buffers them in a FIFO with a registered valid/ready head.
// Optional feature: define SPI_RX_FRAME_ERR_EN to add the frame_err pulse output.
module spi_slave_rx #(
    parameter int unsigned DW          = 12,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned LEAD_IN     = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          sclk,
    input  logic                          cs,
    input  logic                          mosi,
    output logic [DW-1:0]                 dout,
    output logic                          dout_valid,
    input  logic                          dout_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
`ifdef SPI_RX_FRAME_ERR_EN
    output logic                          frame_err,
`endif
    output logic                          overflow
);

    localparam int unsigned AW  = $clog2(FIFO_DEPTH);
    localparam int unsigned BCW = $clog2(DW);
    localparam int unsigned LCW = $clog2(LEAD_IN + 2);

    typedef enum logic [1:0] {StIdle, StLead, StShift, StWaitCs} state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic [SYNC_STAGES-1:0] primed_q, primed_d;
    logic                   sclk_prev_q, sclk_prev_d;
    logic                   armed_q, armed_d;
    logic [LCW-1:0]         lead_cnt_q, lead_cnt_d;
    logic [BCW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [DW-1:0]          shreg_q, shreg_d;
    logic                   push_q, push_d;
    logic [DW-1:0]          push_data_q, push_data_d;
    logic [DW-1:0]          mem_q [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]            count_q, count_d;
    logic [DW-1:0]          dout_q, dout_d;
    logic                   dout_valid_q, dout_valid_d;
    logic                   overflow_q, overflow_d;

    logic sclk_s, cs_s, mosi_s, fall, primed, last_bit;
    logic start_frame, lead_tick, shift_en, push;
    logic pop, full, wr_en;
    logic [DW-1:0] head;

    assign sclk_s   = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s     = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
    assign primed   = primed_q[SYNC_STAGES-1];
    assign fall     = sclk_prev_q & ~sclk_s;
    assign last_bit = (bit_cnt_q == BCW'(DW - 1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // Next-state logic; a raised cs always abandons the frame
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (armed_q && !cs_s) state_d = (LEAD_IN > 0) ? StLead : StShift;
            StLead:   if (cs_s) state_d = StIdle;
                      else if (fall && lead_cnt_q == LCW'(LEAD_IN - 1)) state_d = StShift;
            StShift:  if (cs_s) state_d = StIdle;
                      else if (fall && last_bit) state_d = StWaitCs;
            StWaitCs: if (cs_s) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // FSM outputs: strobes driving the counters, shifter and push
    always_comb begin
        start_frame = (state_q == StIdle) && armed_q && !cs_s;
        lead_tick   = (state_q == StLead) && !cs_s && fall;
        shift_en    = (state_q == StShift) && !cs_s && fall;
        push        = shift_en && last_bit;
    end

    // Synchronisers, edge history and frame datapath next-state
    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        primed_d    = {primed_q[SYNC_STAGES-2:0], 1'b1};
        sclk_prev_d = sclk_s;
        // Only a cs high seen after the chains hold real samples arms a new frame
        armed_d     = (state_d == StIdle) && (armed_q || (primed && cs_s));
        lead_cnt_d  = lead_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        if (start_frame) begin
            lead_cnt_d = '0;
            bit_cnt_d  = '0;
            shreg_d    = '0;
        end
        if (lead_tick) lead_cnt_d = lead_cnt_q + LCW'(1);
        if (shift_en) begin
            shreg_d[bit_cnt_q] = mosi_s;
            bit_cnt_d          = bit_cnt_q + BCW'(1);
        end
        push_d      = push;
        push_data_d = shreg_d;
    end

    // FIFO next-state; the head register bypasses a write landing in the new head slot
    always_comb begin
        pop          = dout_valid_q & dout_ready;
        full         = (count_q == (AW + 1)'(FIFO_DEPTH));
        wr_en        = push_q && (!full || pop);
        overflow_d   = push_q && full && !pop;
        wr_ptr_d     = wr_ptr_q + AW'(wr_en);
        rd_ptr_d     = rd_ptr_q + AW'(pop);
        count_d      = count_q + (AW + 1)'(wr_en) - (AW + 1)'(pop);
        head         = (wr_en && wr_ptr_q == rd_ptr_d) ? push_data_q : mem_q[rd_ptr_d];
        dout_valid_d = (count_d != '0);
        dout_d       = dout_valid_d ? head : dout_q;
    end

    // Datapath and FIFO control registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync_q  <= '0;
            cs_sync_q    <= '1;
            mosi_sync_q  <= '0;
            primed_q     <= '0;
            sclk_prev_q  <= 1'b0;
            armed_q      <= 1'b0;
            lead_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            push_q       <= 1'b0;
            push_data_q  <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            sclk_sync_q  <= sclk_sync_d;
            cs_sync_q    <= cs_sync_d;
            mosi_sync_q  <= mosi_sync_d;
            primed_q     <= primed_d;
            sclk_prev_q  <= sclk_prev_d;
            armed_q      <= armed_d;
            lead_cnt_q   <= lead_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            push_q       <= push_d;
            push_data_q  <= push_data_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            overflow_q   <= overflow_d;
        end
    end

    // FIFO storage, unreset: occupancy is tracked by the pointers
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= push_data_q;
    end

`ifdef SPI_RX_FRAME_ERR_EN
    logic frame_err_q, frame_err_d;

    // Abort with a short frame, or a surplus sclk fall after a complete word
    always_comb begin
        frame_err_d = (cs_s && (state_q == StLead || state_q == StShift)) ||
                      (state_q == StWaitCs && !cs_s && fall);
    end

    // Frame error pulse register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) frame_err_q <= 1'b0;
        else     frame_err_q <= frame_err_d;
    end

    assign frame_err = frame_err_q;
`endif

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign fifo_count = count_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Directed bench for spi_slave_rx: drives SPI frames like the master (11-clk half-period,
// one lead-in sclk pulse, LSB first) and checks delivered words, fill level and overflow.
module tb_spi_slave_rx;

    localparam int HALF = 11;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sclk = 1'b0;
    logic        cs = 1'b1;
    logic        mosi = 1'b0;
    logic        dout_ready = 1'b0;
    logic [11:0] dout;
    logic        dout_valid;
    logic [2:0]  fifo_count;
    logic        overflow;
`ifdef SPI_RX_FRAME_ERR_EN
    logic        frame_err;
    int          ferr_cnt = 0;
`endif

    int          n_checks = 0;
    int          n_err = 0;
    int          ovf_cnt = 0;
    int          ovf_base;
    logic [11:0] got_q[$];
    logic [11:0] exp_q[$];

    spi_slave_rx dut (
        .clk        (clk),
        .rst        (rst),
        .sclk       (sclk),
        .cs         (cs),
        .mosi       (mosi),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .fifo_count (fifo_count),
`ifdef SPI_RX_FRAME_ERR_EN
        .frame_err  (frame_err),
`endif
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    // Record accepted beats and count pulse cycles
    always @(posedge clk) begin
        if (!rst) begin
            if (dout_valid && dout_ready) got_q.push_back(dout);
            if (overflow) ovf_cnt <= ovf_cnt + 1;
`ifdef SPI_RX_FRAME_ERR_EN
            if (frame_err) ferr_cnt <= ferr_cnt + 1;
`endif
        end
    end

    task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
        n_checks++;
        if (got_v !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Send nbits of word; pulse_ready opens a one-cycle ready window aligned with the push
    task automatic spi_frame(input logic [11:0] word, input int nbits, input bit pulse_ready);
        cs = 1'b0;
        wait_clk(HALF);
        sclk = 1'b1; wait_clk(HALF);
        sclk = 1'b0; wait_clk(HALF);
        for (int i = 0; i < nbits; i++) begin
            sclk = 1'b1; mosi = word[i]; wait_clk(HALF);
            sclk = 1'b0;
            if (pulse_ready && i == nbits - 1) begin
                wait_clk(3);
                dout_ready = 1'b1;
                wait_clk(1);
                dout_ready = 1'b0;
                wait_clk(HALF - 4);
            end else begin
                wait_clk(HALF);
            end
        end
        cs = 1'b1; mosi = 1'b0;
        wait_clk(2 * HALF);
    endtask

    // Accept words until exp_q.size() beats are seen (bounded), then compare in order
    task automatic drain(input string tag);
        dout_ready = 1'b1;
        for (int k = 0; k < 300 && got_q.size() < exp_q.size(); k++) wait_clk(1);
        dout_ready = 1'b0;
        wait_clk(3);
        check({tag, "_n"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check({tag, "_w"}, {20'h0, got_q[i]}, {20'h0, exp_q[i]});
        check({tag, "_empty"}, {31'h0, dout_valid}, 0);
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        wait_clk(3);
        check("rst_dout", {20'h0, dout}, 0);
        check("rst_valid", {31'h0, dout_valid}, 0);
        check("rst_count", {29'h0, fifo_count}, 0);
        check("rst_ovf", {31'h0, overflow}, 0);
        rst = 1'b0;
        wait_clk(2 * HALF);

        // 1: single word with ready held high
        ovf_base = ovf_cnt;
        dout_ready = 1'b1;
        spi_frame(12'hA5C, 12, 1'b0);
        exp_q = '{12'hA5C};
        drain("t1");
        check("t1_ovf", ovf_cnt - ovf_base, 0);

        // 2: three words buffered, then drained in order
        spi_frame(12'h001, 12, 1'b0);
        spi_frame(12'h800, 12, 1'b0);
        spi_frame(12'hFFF, 12, 1'b0);
        check("t2_count", {29'h0, fifo_count}, 3);
        check("t2_dout_hold", {20'h0, dout}, 12'h001);
        exp_q = '{12'h001, 12'h800, 12'hFFF};
        drain("t2");

        // 3: fifth word dropped with a single-cycle overflow
        ovf_base = ovf_cnt;
        spi_frame(12'h0F0, 12, 1'b0);
        spi_frame(12'h00F, 12, 1'b0);
        spi_frame(12'hF00, 12, 1'b0);
        spi_frame(12'h5A5, 12, 1'b0);
        check("t3_full", {29'h0, fifo_count}, 4);
        check("t3_ovf0", ovf_cnt - ovf_base, 0);
        spi_frame(12'hABC, 12, 1'b0);
        check("t3_count", {29'h0, fifo_count}, 4);
        check("t3_ovf1", ovf_cnt - ovf_base, 1);
        exp_q = '{12'h0F0, 12'h00F, 12'hF00, 12'h5A5};
        drain("t3");

        // 4: aborted partial frame discarded
`ifdef SPI_RX_FRAME_ERR_EN
        ferr_cnt = 0;
`endif
        spi_frame(12'h3C3, 6, 1'b0);
        check("t4_count0", {29'h0, fifo_count}, 0);
`ifdef SPI_RX_FRAME_ERR_EN
        check("t4_ferr", ferr_cnt, 1);
`endif
        spi_frame(12'h123, 12, 1'b0);
        exp_q = '{12'h123};
        drain("t4");

        // 5: push into full FIFO coinciding with a pop
        ovf_base = ovf_cnt;
        spi_frame(12'h101, 12, 1'b0);
        spi_frame(12'h202, 12, 1'b0);
        spi_frame(12'h303, 12, 1'b0);
        spi_frame(12'h404, 12, 1'b0);
        check("t5_full", {29'h0, fifo_count}, 4);
        spi_frame(12'h505, 12, 1'b1);
        check("t5_count", {29'h0, fifo_count}, 4);
        check("t5_ovf", ovf_cnt - ovf_base, 0);
        exp_q = '{12'h101, 12'h202, 12'h303, 12'h404, 12'h505};
        drain("t5");

        // 6: reset mid-frame with two words buffered
        spi_frame(12'h111, 12, 1'b0);
        spi_frame(12'h222, 12, 1'b0);
        check("t6_pre", {29'h0, fifo_count}, 2);
        cs = 1'b0; wait_clk(HALF);
        sclk = 1'b1; wait_clk(HALF);
        sclk = 1'b0; wait_clk(HALF);
        for (int i = 0; i < 5; i++) begin
            sclk = 1'b1; mosi = 1'(12'h555 >> i); wait_clk(HALF);
            sclk = 1'b0; wait_clk(HALF);
        end
        rst = 1'b1;
        #1;
        check("t6_rst_valid", {31'h0, dout_valid}, 0);
        check("t6_rst_count", {29'h0, fifo_count}, 0);
        check("t6_rst_dout", {20'h0, dout}, 0);
        check("t6_rst_ovf", {31'h0, overflow}, 0);
        wait_clk(3);
        rst = 1'b0;
        for (int i = 5; i < 12; i++) begin
            sclk = 1'b1; mosi = 1'(12'h555 >> i); wait_clk(HALF);
            sclk = 1'b0; wait_clk(HALF);
        end
        cs = 1'b1; mosi = 1'b0;
        wait_clk(2 * HALF);
        check("t6_ignored", {29'h0, fifo_count}, 0);
        check("t6_novalid", {31'h0, dout_valid}, 0);
        got_q.delete();
        spi_frame(12'h0AA, 12, 1'b0);
        exp_q = '{12'h0AA};
        drain("t6");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
